bcd_signed_addsub_ctrl: RTL and testbench

//  Sequencer for the fixed-latency BCD significand add/subtract datapath of the decimal FPU.

---
 rtl/bcd_signed_addsub_ctrl_pkg.sv | 19 +
 rtl/bcd_signed_addsub_ctrl_fifo.sv | 72 +++++++
 rtl/bcd_signed_addsub_ctrl.sv | 153 +++++++++++++++
 tb/tb_bcd_signed_addsub_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_signed_addsub_ctrl_pkg.sv
// Shared types for the signed-magnitude BCD add/subtract controller.
// The result record is declared in the top because its width follows the N parameter.
package bcd_signed_addsub_ctrl_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } bcd_op_e;

  // Signs and the requested op collapse into a single magnitude add or subtract.
  function automatic bcd_op_e eff_op(input logic sa, input logic sb, input logic op);
    return bcd_op_e'(sa ^ sb ^ op);
  endfunction

endpackage

// File: rtl/bcd_signed_addsub_ctrl_fifo.sv
// Synchronous FIFO for controller results, with a registered storage array.
// It accepts a push and a pop in the same cycle, including when the FIFO is full.
module bcd_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Upstream credit accounting guarantees room for every push.
  push_into_full_a: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/bcd_signed_addsub_ctrl.sv
// Issue and retire sequencer for the fixed-latency BCD significand add/subtract datapath.
// It aligns sign tags with the datapath output, fixes up the result sign, and buffers results behind credits.
module bcd_signed_addsub_ctrl
  import bcd_signed_addsub_ctrl_pkg::*;
#(
  parameter int N          = 25,
  parameter int DP_LAT     = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*4-1:0]   in_a,
  input  logic             in_sa,
  input  logic [N*4-1:0]   in_b,
  input  logic             in_sb,
  input  logic             in_op,
  output logic             dp_sub,
  output logic [N*4-1:0]   dp_a,
  output logic [N*4-1:0]   dp_b,
  input  logic [N*4-1:0]   dp_o,
  input  logic             dp_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*4-1:0]   out_mag,
  output logic             out_sign,
  output logic             out_ovf,
  output logic             busy
);

  localparam int W  = N * DIGIT_W;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    bcd_digit_t [N-1:0] mag;
    logic               sign;
    logic               ovf;
  } bcd_smag_res_t;

  typedef struct packed {
    logic    vld;
    logic    sa;
    bcd_op_e op;
  } tag_t;

  tag_t [DP_LAT-1:0] tag_q, tag_d;
  tag_t              arr_tag;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic              dp_sub_q, dp_sub_d;
  logic [W-1:0]      dp_a_q, dp_a_d;
  logic [W-1:0]      dp_b_q, dp_b_d;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              accept;
  logic              pop;
  bcd_op_e           eff;
  bcd_smag_res_t     push_res;
  bcd_smag_res_t     pop_res;

  // Credits come only from registered counts, so a pop frees its slot one cycle later.
  assign in_ready = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
  assign accept   = in_valid & in_ready;
  assign eff      = eff_op(in_sa, in_sb, in_op);
  assign arr_tag  = tag_q[DP_LAT-1];

  always_comb begin
    dp_sub_d = dp_sub_q;
    dp_a_d   = dp_a_q;
    dp_b_d   = dp_b_q;
    if (accept) begin
      dp_sub_d = (eff == OP_SUB);
      dp_a_d   = in_a;
      dp_b_d   = in_b;
    end
  end

  assign dp_sub = dp_sub_d;
  assign dp_a   = dp_a_d;
  assign dp_b   = dp_b_d;

  always_comb begin
    tag_d        = tag_q;
    tag_d[0].vld = accept;
    tag_d[0].sa  = in_sa;
    tag_d[0].op  = eff;
    for (int i = 1; i < DP_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, arr_tag.vld})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  // A subtract without carry means B > A, so the true result has the opposite sign of A.
  always_comb begin
    push_res.mag = dp_o;
    if (arr_tag.op == OP_ADD) begin
      push_res.sign = arr_tag.sa;
      push_res.ovf  = dp_co;
    end else begin
      push_res.sign = dp_co ? arr_tag.sa : ~arr_tag.sa;
      push_res.ovf  = 1'b0;
    end
    if (dp_o == '0) begin
      push_res.sign = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q      <= '0;
      inflight_q <= '0;
      dp_sub_q   <= 1'b0;
      dp_a_q     <= '0;
      dp_b_q     <= '0;
    end else begin
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      dp_sub_q   <= dp_sub_d;
      dp_a_q     <= dp_a_d;
      dp_b_q     <= dp_b_d;
    end
  end

  bcd_sync_fifo #(
    .WIDTH ($bits(bcd_smag_res_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (arr_tag.vld),
    .push_data (push_res),
    .pop       (pop),
    .pop_data  (pop_res),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign out_mag   = pop_res.mag;
  assign out_sign  = pop_res.sign;
  assign out_ovf   = pop_res.ovf;
  assign busy      = (inflight_q != '0) | ~fifo_empty;

endmodule

// File: tb/tb_bcd_signed_addsub_ctrl.sv
// Directed and random bench for bcd_signed_addsub_ctrl with a 3-cycle behavioural datapath.
// Expected results come from signed integer arithmetic on the operand values.
module tb_bcd_signed_addsub_ctrl;

  localparam int N      = 4;
  localparam int DP_LAT = 3;
  localparam int DEPTH  = 8;
  localparam int W      = N * 4;
  localparam int MOD    = 10000;

  typedef struct {
    int   mag;
    logic sign;
    logic ovf;
    int   acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic         in_sa = 1'b0;
  logic [W-1:0] in_b = '0;
  logic         in_sb = 1'b0;
  logic         in_op = 1'b0;
  logic         dp_sub;
  logic [W-1:0] dp_a;
  logic [W-1:0] dp_b;
  logic [W-1:0] dp_o;
  logic         dp_co;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_mag;
  logic         out_sign;
  logic         out_ovf;
  logic         busy;

  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   naccepts = 0;
  int   npops = 0;
  exp_t sb_q[$];

  logic         iss_sub = 1'b0;
  int           iss_a = 0;
  int           iss_b = 0;
  logic [W-1:0] pipe_o [DP_LAT];
  logic         pipe_co [DP_LAT];

  always #5 clk = ~clk;

  bcd_signed_addsub_ctrl #(
    .N          (N),
    .DP_LAT     (DP_LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_sa     (in_sa),
    .in_b      (in_b),
    .in_sb     (in_sb),
    .in_op     (in_op),
    .dp_sub    (dp_sub),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_o      (dp_o),
    .dp_co     (dp_co),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_sign  (out_sign),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] x);
    int v;
    v = 0;
    for (int i = N - 1; i >= 0; i--) begin
      v = v * 10 + int'(x[4*i +: 4]);
    end
    return v;
  endfunction

  // Datapath stand-in: |A-B| with carry=A>=B, or A+B modulo 10^N with decimal carry.
  always @(posedge clk) begin
    if (iss_sub) begin
      pipe_o[0]  <= int2bcd(iss_a >= iss_b ? iss_a - iss_b : iss_b - iss_a);
      pipe_co[0] <= (iss_a >= iss_b);
    end else begin
      pipe_o[0]  <= int2bcd((iss_a + iss_b) % MOD);
      pipe_co[0] <= ((iss_a + iss_b) >= MOD);
    end
    for (int i = 1; i < DP_LAT; i++) begin
      pipe_o[i]  <= pipe_o[i-1];
      pipe_co[i] <= pipe_co[i-1];
    end
  end

  assign dp_o  = pipe_o[DP_LAT-1];
  assign dp_co = pipe_co[DP_LAT-1];

  function automatic exp_t refModel(input logic sa, input int a, input logic sb, input int b,
                                    input logic op, input int acc);
    exp_t e;
    int   va;
    int   vb;
    int   r;
    int   m;
    va = sa ? -a : a;
    vb = sb ? -b : b;
    r  = op ? va - vb : va + vb;
    m  = (r < 0) ? -r : r;
    e.mag  = m % MOD;
    e.ovf  = (m >= MOD);
    e.sign = (r < 0) && (e.mag != 0);
    e.acc  = acc;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drives one cycle of inputs at the falling edge, checks outputs, and updates the scoreboard.
  task automatic applyStimulus(input logic v, input logic sa, input int a, input logic sb,
                               input int b, input logic op, input logic ordy);
    exp_t e;
    logic exp_vld;
    in_valid  = v;
    in_sa     = sa;
    in_a      = int2bcd(a);
    in_sb     = sb;
    in_b      = int2bcd(b);
    in_op     = op;
    out_ready = ordy;
    #1;
    iss_sub = dp_sub;
    iss_a   = bcd2int(dp_a);
    iss_b   = bcd2int(dp_b);
    checkOutput("in_ready", 32'(in_ready), 32'(sb_q.size() < DEPTH));
    checkOutput("busy", 32'(busy), 32'(sb_q.size() != 0));
    exp_vld = 1'b0;
    if (sb_q.size() != 0) begin
      exp_vld = (cyc >= sb_q[0].acc + DP_LAT + 1);
    end
    checkOutput("out_valid", 32'(out_valid), 32'(exp_vld));
    if (out_valid && ordy && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checkOutput("out_mag", 32'(bcd2int(out_mag)), 32'(e.mag));
      checkOutput("out_sign", 32'(out_sign), 32'(e.sign));
      checkOutput("out_ovf", 32'(out_ovf), 32'(e.ovf));
      npops++;
    end
    if (v && in_ready) begin
      checkOutput("dp_sub", 32'(dp_sub), 32'(sa ^ sb ^ op));
      checkOutput("dp_a", 32'(dp_a), 32'(int2bcd(a)));
      checkOutput("dp_b", 32'(dp_b), 32'(int2bcd(b)));
      sb_q.push_back(refModel(sa, a, sb, b, op, cyc));
      naccepts++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, ordy);
    end
  endtask

  task automatic doReset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    cyc++;
    checkOutput("rst_in_ready", 32'(in_ready), 32'(1));
    checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_out_mag", 32'(out_mag), 32'(0));
    checkOutput("rst_out_sign", 32'(out_sign), 32'(0));
    checkOutput("rst_out_ovf", 32'(out_ovf), 32'(0));
    checkOutput("rst_dp_sub", 32'(dp_sub), 32'(0));
    checkOutput("rst_dp_a", 32'(dp_a), 32'(0));
    checkOutput("rst_dp_b", 32'(dp_b), 32'(0));
  endtask

  initial begin
    int   acc0;
    int   pop0;
    logic sa, sb, op, v, ordy;
    int   a, b;

    @(negedge clk);
    doReset();

    $display("[TB] directed: sign fix-up cases");
    applyStimulus(1'b1, 1'b0, 123, 1'b0, 45, 1'b1, 1'b1);
    idle(6, 1'b1);
    applyStimulus(1'b1, 1'b0, 45, 1'b0, 123, 1'b1, 1'b1);
    idle(6, 1'b1);
    applyStimulus(1'b1, 1'b1, 500, 1'b1, 700, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 9999, 1'b0, 1, 1'b0, 1'b1);
    idle(6, 1'b1);
    applyStimulus(1'b1, 1'b0, 250, 1'b0, 250, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 250, 1'b0, 250, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 9999, 1'b1, 1, 1'b0, 1'b1);
    idle(6, 1'b1);

    $display("[TB] directed: back-pressure fill and drain");
    acc0 = naccepts;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'(i % 2), 100 * i + 7, 1'b0, 11 * i, 1'(i % 3 == 0), 1'b0);
    end
    checkOutput("fill_accepts", 32'(naccepts - acc0), 32'(DEPTH));
    checkOutput("fill_in_ready", 32'(in_ready), 32'(0));
    pop0 = npops;
    idle(12, 1'b1);
    checkOutput("drain_pops", 32'(npops - pop0), 32'(DEPTH));

    $display("[TB] directed: sustained throughput");
    acc0 = naccepts;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 9000 + i, 1'b1, 37 * i, 1'b0, 1'b1);
    end
    checkOutput("stream_accepts", 32'(naccepts - acc0), 32'(20));
    idle(8, 1'b1);

    $display("[TB] directed: reset with work in flight");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1111 * (i + 1), 1'b0, 5, 1'b0, 1'b0);
    end
    idle(1, 1'b0);
    checkOutput("pre_rst_busy", 32'(busy), 32'(1));
    doReset();
    idle(10, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      sa   = 1'($urandom_range(0, 1));
      sb   = 1'($urandom_range(0, 1));
      op   = 1'($urandom_range(0, 1));
      b    = int'($urandom_range(0, MOD - 1));
      case ($urandom_range(0, 5))
        0:       a = b;
        1:       a = MOD - 1;
        2:       a = 0;
        default: a = int'($urandom_range(0, MOD - 1));
      endcase
      applyStimulus(v, sa, a, sb, b, op, ordy);
    end
    idle(20, 1'b1);
    checkOutput("drained", 32'(sb_q.size()), 32'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
